// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment scan driver with double-buffered
// digit data, leading-zero suppression and per-slot ghost blanking.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic                    frame_done
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int DW = 4 * NUM_DIGITS;

  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{ACTIVE_LOW}};
  localparam logic [6:0]            SEG_OFF = {7{ACTIVE_LOW}};
  localparam logic                  DP_OFF  = ACTIVE_LOW;

  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DW-1:0]         act_dig_q, act_dig_d;
  logic [NUM_DIGITS-1:0] act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0] act_en_q, act_en_d;
  logic [DW-1:0]         pend_dig_q, pend_dig_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0] pend_en_q, pend_en_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  fd_q, fd_d;

  logic                  slot_end;
  logic                  frame_wrap;
  logic                  in_blank;
  logic                  suppress;
  logic [NUM_DIGITS-1:0] lead_zero;
  logic                  all_zero;
  logic [NUM_DIGITS-1:0] onehot;
  logic [3:0]            cur_nib;
  logic                  cur_en;
  logic                  cur_dp;
  logic                  cur_lz;
  logic [NUM_DIGITS-1:0] an_l;
  logic [6:0]            seg_l;
  logic                  dp_l;

  // Active-low glyph table, {g,f,e,d,c,b,a}
  function automatic logic [6:0] glyph(input logic [3:0] h);
    logic [6:0] g;
    case (h)
      4'h0:    g = 7'b1000000;
      4'h1:    g = 7'b1111001;
      4'h2:    g = 7'b0100100;
      4'h3:    g = 7'b0110000;
      4'h4:    g = 7'b0011001;
      4'h5:    g = 7'b0010010;
      4'h6:    g = 7'b0000010;
      4'h7:    g = 7'b1111000;
      4'h8:    g = 7'b0000000;
      4'h9:    g = 7'b0010000;
      4'hA:    g = 7'b0001000;
      4'hB:    g = 7'b0000011;
      4'hC:    g = 7'b1000110;
      4'hD:    g = 7'b0100001;
      4'hE:    g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  assign slot_end   = (presc_q == PRESC_LAST);
  assign frame_wrap = slot_end && (idx_q == IDX_LAST);

  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      assign in_blank = (presc_q < PW'(BLANK_CYCLES));
    end else begin : g_noblank
      assign in_blank = 1'b0;
    end
  endgenerate

  always_comb begin
    presc_d = slot_end ? '0 : presc_q + PW'(1);
    idx_d   = idx_q;
    if (slot_end) begin
      idx_d = frame_wrap ? '0 : idx_q + IW'(1);
    end
  end

  // A load coinciding with the wrap bypasses the pending stage
  always_comb begin
    act_dig_d    = act_dig_q;
    act_dp_d     = act_dp_q;
    act_en_d     = act_en_q;
    pend_dig_d   = pend_dig_q;
    pend_dp_d    = pend_dp_q;
    pend_en_d    = pend_en_q;
    pend_valid_d = pend_valid_q;
    if (load && frame_wrap) begin
      act_dig_d    = digits_in;
      act_dp_d     = dp_in;
      act_en_d     = digit_en;
      pend_valid_d = 1'b0;
    end else begin
      if (frame_wrap && pend_valid_q) begin
        act_dig_d    = pend_dig_q;
        act_dp_d     = pend_dp_q;
        act_en_d     = pend_en_q;
        pend_valid_d = 1'b0;
      end
      if (load) begin
        pend_dig_d   = digits_in;
        pend_dp_d    = dp_in;
        pend_en_d    = digit_en;
        pend_valid_d = 1'b1;
      end
    end
  end

  // lead_zero[i]: nibbles NUM_DIGITS-1 down to i are all zero
  always_comb begin
    lead_zero = '0;
    all_zero  = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      all_zero     = all_zero & (act_dig_q[4*i +: 4] == 4'h0);
      lead_zero[i] = all_zero;
    end
  end

  always_comb begin
    onehot  = '0;
    cur_nib = '0;
    cur_en  = 1'b0;
    cur_dp  = 1'b0;
    cur_lz  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        onehot[i] = 1'b1;
        cur_nib   = act_dig_q[4*i +: 4];
        cur_en    = act_en_q[i];
        cur_dp    = act_dp_q[i];
        cur_lz    = lead_zero[i];
      end
    end
  end

  assign suppress = !cur_en ||
                    (lz_blank && (idx_q != '0) && cur_lz);

  always_comb begin
    an_l  = '1;
    seg_l = 7'h7F;
    dp_l  = 1'b1;
    if (!in_blank && !suppress) begin
      an_l  = ~onehot;
      seg_l = glyph(cur_nib);
      dp_l  = ~cur_dp;
    end
    an_d  = ACTIVE_LOW ? an_l  : ~an_l;
    seg_d = ACTIVE_LOW ? seg_l : ~seg_l;
    dp_d  = ACTIVE_LOW ? dp_l  : ~dp_l;
    fd_d  = frame_wrap;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      idx_q        <= '0;
      act_dig_q    <= '0;
      act_dp_q     <= '0;
      act_en_q     <= '0;
      pend_dig_q   <= '0;
      pend_dp_q    <= '0;
      pend_en_q    <= '0;
      pend_valid_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= DP_OFF;
      fd_q         <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      act_dig_q    <= act_dig_d;
      act_dp_q     <= act_dp_d;
      act_en_q     <= act_en_d;
      pend_dig_q   <= pend_dig_d;
      pend_dp_q    <= pend_dp_d;
      pend_en_q    <= pend_en_d;
      pend_valid_q <= pend_valid_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      fd_q         <= fd_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: 4-digit active-low and
// 8-digit active-high instances, table vectors plus scoreboard.
module tb_seven_seg_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst4, ld4, lz4;
  logic [15:0] dig4;
  logic [3:0]  dp4, en4, an4;
  logic [6:0]  seg4;
  logic        dpo4, fd4;

  logic        rst8, ld8, lz8;
  logic [31:0] dig8;
  logic [7:0]  dp8, en8, an8;
  logic [6:0]  seg8;
  logic        dpo8, fd8;

  seven_seg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4),
    .BLANK_CYCLES(1), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(rst4), .digits_in(dig4),
    .dp_in(dp4), .digit_en(en4), .lz_blank(lz4),
    .load(ld4), .an(an4), .seg(seg4), .dp(dpo4),
    .frame_done(fd4)
  );

  seven_seg_scan_driver #(
    .NUM_DIGITS(8), .REFRESH_DIV(2),
    .BLANK_CYCLES(0), .ACTIVE_LOW(1'b0)
  ) dut8 (
    .clk(clk), .reset(rst8), .digits_in(dig8),
    .dp_in(dp8), .digit_en(en8), .lz_blank(lz8),
    .load(ld8), .an(an8), .seg(seg8), .dp(dpo8),
    .frame_done(fd8)
  );

  typedef struct packed {
    logic [7:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fd;
  } obs_t;

  typedef struct packed {
    logic [15:0]     dig;
    logic [3:0]      dpv;
    logic [3:0]      en;
    logic            lz;
    logic [3:0]      shown;
    logic [3:0]      dpon;
    logic [3:0][6:0] seg;
  } vec_t;

  obs_t sb[$];
  vec_t vt[10];
  vec_t blank_v;
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(
    input logic [15:0] d, input logic [3:0] p,
    input logic [3:0] e, input logic l,
    input logic [3:0] sh, input logic [3:0] pon,
    input logic [6:0] s3, input logic [6:0] s2,
    input logic [6:0] s1, input logic [6:0] s0);
    vec_t v;
    v.dig = d; v.dpv = p; v.en = e; v.lz = l;
    v.shown = sh; v.dpon = pon;
    v.seg = {s3, s2, s1, s0};
    return v;
  endfunction

  task automatic check(input string name,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic push_frame4(input vec_t v);
    obs_t o;
    logic [3:0] oh;
    int s, c;
    for (int j = 0; j < 16; j++) begin
      s = j / 4;
      c = j % 4;
      oh = 4'b0001 << s;
      if (c == 0 || !v.shown[s]) begin
        o.an = 8'h0F; o.seg = 7'h7F; o.dp = 1'b1;
      end else begin
        o.an  = {4'h0, ~oh};
        o.seg = v.seg[s];
        o.dp  = ~v.dpon[s];
      end
      o.fd = (j == 15);
      sb.push_back(o);
    end
  endtask

  task automatic run_frame4(input string tag, input vec_t e,
                            input int load_at, input vec_t nv);
    obs_t o, got;
    lz4 = e.lz;
    push_frame4(e);
    for (int j = 0; j < 16; j++) begin
      if (j == load_at) begin
        ld4 = 1'b1; dig4 = nv.dig; dp4 = nv.dpv; en4 = nv.en;
      end
      @(negedge clk);
      ld4 = 1'b0;
      got = {4'h0, an4, seg4, dpo4, fd4};
      o = sb.pop_front();
      check($sformatf("%s cyc%0d", tag, j), 32'(got), 32'(o));
    end
  endtask

  task automatic run_frame8(input string tag, input logic [6:0] sv,
                            input logic [7:0] dpv, input int load_at,
                            input logic [31:0] nd, input logic [7:0] ndp);
    obs_t o, got;
    logic [7:0] oh;
    for (int j = 0; j < 16; j++) begin
      oh = 8'h01 << (j / 2);
      o.an = oh; o.seg = sv;
      o.dp = dpv[j/2]; o.fd = (j == 15);
      sb.push_back(o);
    end
    for (int j = 0; j < 16; j++) begin
      if (j == load_at) begin
        ld8 = 1'b1; dig8 = nd; dp8 = ndp;
      end
      @(negedge clk);
      ld8 = 1'b0;
      got = {an8, seg8, dpo8, fd8};
      o = sb.pop_front();
      check($sformatf("%s cyc%0d", tag, j), 32'(got), 32'(o));
    end
  endtask

  task automatic wait_fd(input bit wide, input string name,
                         input int n);
    int i;
    for (i = 1; i <= 40; i++) begin
      @(negedge clk);
      ld4 = 1'b0;
      ld8 = 1'b0;
      if (wide ? fd8 : fd4) break;
    end
    check(name, 32'(i), 32'(n));
  endtask

  initial begin
    vt[0] = mk(16'h0000, 4'h0, 4'hF, 1'b0, 4'hF, 4'h0,
               7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000);
    vt[1] = mk(16'h1234, 4'h0, 4'hF, 1'b0, 4'hF, 4'h0,
               7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001);
    vt[2] = mk(16'h0050, 4'h0, 4'hF, 1'b1, 4'b0011, 4'h0,
               7'h7F, 7'h7F, 7'b0010010, 7'b1000000);
    vt[3] = mk(16'h0000, 4'h0, 4'hF, 1'b1, 4'b0001, 4'h0,
               7'h7F, 7'h7F, 7'h7F, 7'b1000000);
    vt[4] = mk(16'h0000, 4'b0011, 4'b0101, 1'b0, 4'b0101, 4'b0001,
               7'h7F, 7'b1000000, 7'h7F, 7'b1000000);
    vt[5] = mk(16'h89AB, 4'h0, 4'hF, 1'b0, 4'hF, 4'h0,
               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011);
    vt[6] = mk(16'hCDEF, 4'hF, 4'hF, 1'b0, 4'hF, 4'hF,
               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110);
    vt[7] = mk(16'h5670, 4'h0, 4'hF, 1'b0, 4'hF, 4'h0,
               7'b0010010, 7'b0000010, 7'b1111000, 7'b1000000);
    vt[8] = mk(16'h0305, 4'h0, 4'hF, 1'b1, 4'b0111, 4'h0,
               7'h7F, 7'b0110000, 7'b1000000, 7'b0010010);
    vt[9] = mk(16'hABCD, 4'h0, 4'hF, 1'b0, 4'hF, 4'h0,
               7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001);
    blank_v = mk(16'h0000, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0,
                 7'h7F, 7'h7F, 7'h7F, 7'h7F);

    rst4 = 1'b1; ld4 = 1'b0; lz4 = 1'b0;
    dig4 = '0; dp4 = '0; en4 = '0;
    rst8 = 1'b1; ld8 = 1'b0; lz8 = 1'b0;
    dig8 = '0; dp8 = '0; en8 = '0;
    repeat (3) @(negedge clk);
    check("reset4 outputs", 32'({an4, seg4, dpo4, fd4}),
          32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    check("reset8 outputs", 32'({an8, seg8, dpo8, fd8}), 32'h0);

    rst4 = 1'b0;
    ld4 = 1'b1; dig4 = vt[0].dig; dp4 = vt[0].dpv; en4 = vt[0].en;
    wait_fd(1'b0, "first frame_done4", 16);

    for (int k = 0; k < 8; k++)
      run_frame4($sformatf("vec%0d", k), vt[k], 5, vt[k+1]);
    run_frame4("vec8", vt[8], 15, vt[9]);
    check("pend_valid after wrap load", 32'(dut.pend_valid_q), 32'h0);
    run_frame4("wrap load ABCD", vt[9], -1, vt[9]);

    for (int j = 0; j < 9; j++) begin
      if (j == 2) begin
        ld4 = 1'b1; dig4 = vt[7].dig; dp4 = vt[7].dpv; en4 = vt[7].en;
      end
      @(negedge clk);
      ld4 = 1'b0;
    end
    rst4 = 1'b1;
    @(negedge clk);
    check("midreset outputs", 32'({an4, seg4, dpo4, fd4}),
          32'({4'hF, 7'h7F, 1'b1, 1'b0}));
    check("midreset buffers",
          32'({dut.act_dig_q, dut.pend_valid_q}), 32'h0);
    check("midreset counters",
          32'({dut.idx_q, dut.presc_q}), 32'h0);
    rst4 = 1'b0;
    wait_fd(1'b0, "restart frame_done4", 16);
    run_frame4("after reset blank", blank_v, 3, vt[1]);
    run_frame4("after reset 1234", vt[1], -1, vt[1]);

    rst8 = 1'b0;
    ld8 = 1'b1; dig8 = 32'h8888_8888; dp8 = 8'h00; en8 = 8'hFF;
    wait_fd(1'b1, "first frame_done8", 16);
    run_frame8("w8 eights", 7'h7F, 8'h00, 3, 32'h1111_1111, 8'hAA);
    run_frame8("w8 ones", 7'b0000110, 8'hAA, -1, 32'h0, 8'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_driver.md
# seven_seg_scan_driver

Parametrised time-multiplexed seven-segment display driver for the calculator's display path: it scans NUM_DIGITS digits with a programmable refresh rate and drives one-hot anodes, hex-decoded segments and a decimal point. It adds a per-slot ghosting blank interval, per-digit enables, leading-zero suppression and a tear-free double-buffered update. Results from the calculator datapath feed it; its outputs go straight to the board pins.

## Interface
- NUM_DIGITS, 4, digit count; legal range 2..8
- REFRESH_DIV, 100000, clk cycles per digit slot; must be ≥2 (100 MHz gives 1 ms per slot)
- BLANK_CYCLES, 2, cycles at the start of each slot with all anodes off; must be < REFRESH_DIV
- ACTIVE_LOW, 1, 1 = anodes, segments and dp are active-low; 0 = active-high
- clk  in  1  system clock; all logic on the rising edge
- reset  in  1  synchronous, active-high
- digits_in  in  4*NUM_DIGITS  hex nibbles; nibble i (bits 4i+3:4i) is digit i, digit 0 rightmost
- dp_in  in  NUM_DIGITS  decimal point request per digit
- digit_en  in  NUM_DIGITS  1 = digit displayed, 0 = slot forced blank
- lz_blank  in  1  enables leading-zero suppression
- load  in  1  single-cycle strobe; captures digits_in, dp_in and digit_en into the pending buffer
- an  out  NUM_DIGITS  one-hot anode drive
- seg  out  7  {g,f,e,d,c,b,a}
- dp  out  1  decimal point
- frame_done  out  1  one-cycle pulse per completed scan frame

## Operation
- Prescaler counts 0..REFRESH_DIV-1 and wraps. At its terminal count the digit index advances; index NUM_DIGITS-1 wraps to 0 (frame wrap).
- Double buffer: load writes the pending buffer and sets pending_valid; later loads overwrite it. On frame wrap with pending_valid set, active ← pending and pending_valid clears. Displayed data always comes from active, so a frame never mixes old and new values.
- Load in the same cycle as frame wrap: the inputs go directly into active, and pending_valid ends cleared.
- Slot display: with prescaler < BLANK_CYCLES, all anodes are off. Otherwise an[index] is on, unless the digit is blanked.
- A digit is blanked when digit_en[index]=0, or when lz_blank=1, index≠0 and every active nibble from NUM_DIGITS-1 down to index is 0. Digit 0 is never suppressed by lz_blank.
- Blanked digit: anode, all segments and dp are off.
- Shown digit: seg is the hex glyph. dp is on iff dp_in[index] (active copy) is set.
- Active-low glyphs: 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110. With ACTIVE_LOW=0, an, seg and dp are bitwise inverted.
- lz_blank is sampled live. Everything else that is displayed comes from the active buffer.

## Timing
- Reset values: prescaler 0, index 0, active and pending buffers 0, pending_valid 0, frame_done 0; an, seg and dp all at their off level (ACTIVE_LOW=1: an all 1s, seg 1111111, dp 1).
- an, seg, dp and frame_done are registered. They reflect the index, prescaler and active contents of the previous cycle (1-cycle latency).
- Slot length is exactly REFRESH_DIV cycles and frame length is NUM_DIGITS×REFRESH_DIV cycles. frame_done is high for one cycle every frame, one cycle after the wrap edge.
- New data first appears in the digit-0 slot of the frame after the wrap in which it is transferred.
- Reset mid-frame: on the next edge all state returns to reset values, any pending load is discarded, and scanning restarts at digit 0.
- With BLANK_CYCLES=0 there is no off interval; anodes switch directly between slots.

## Test plan
Parameters for scenarios 1–5: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, ACTIVE_LOW=1.
- Reset, then release with digit_en=1111 and zero data → an repeats 1111,1110,1110,1110, 1111,1101×3, 1111,1011×3, 1111,0111×3; seg=1000000 in every shown slot; frame_done pulses every 16 cycles.
- Load digits_in=16'h1234 mid-frame → current frame still shows 0s. After the next wrap: slot0 seg 0011001, slot1 0110000, slot2 0100100, slot3 1111001.
- lz_blank=1 with data 16'h0050 → slots 3 and 2 keep an=1111; slot1 shows 0010010; slot0 shows 1000000. With data 0000, only slot0 lights, showing 0.
- digit_en=0101, dp_in=0011 → slots 1 and 3 stay fully off (dp=1); dp=0 only during slot0.
- Load asserted on the exact wrap cycle with 16'hABCD → ABCD is shown in the immediately following frame and pending_valid=0. Reset during slot2 → next cycle an=1111, seg=1111111, active=0, and the scan restarts at slot0.
- NUM_DIGITS=8, ACTIVE_LOW=0, REFRESH_DIV=2, BLANK_CYCLES=0 → an walks 00000001..10000000 and wraps; glyph 8 gives seg=1111111; frame_done every 16 cycles.
